// File: rtl/uart_pkg.sv
// Shared UART definitions: bit period, frame width and receiver states.
// The transmitter imports the same package so both ends agree on timing.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 88;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the reset level of both flops (idle level of the line).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to resolve metastability on the async input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments keep the two stages a true shift;
      // blocking here would collapse them into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge on the synchronized line,
// re-centres on the start bit, then samples each following bit at its
// centre using a free-running bit-period counter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  rx_state_e            state, state_nxt;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic bit_tick;   // counter at the end of a full bit period
  logic half_tick;  // counter at the start-bit centre
  logic cnt_clr;
  logic shift_en;
  logic done_ok;
  logic done_err;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (half_tick) begin
          cnt_clr   = 1'b1;
          // A line already back high at the start-bit centre was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          done_ok   = rx_s;
          done_err  = !rx_s;
          state_nxt = rx_s ? IDLE : BRK;
        end
      end
      BRK: begin
        // Hold off until the line returns high so a break cannot retrigger.
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-period counter: wraps at CLKS_PER_BIT-1 or clears on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (cnt_clr || bit_tick) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  // Output byte and one-cycle completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= done_ok;
      frame_err  <= done_err;
      if (done_ok || done_err) data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, hand-written corner
// sequences (timing, glitch, break, back-to-back, mid-frame reset) and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = CLKS_PER_BIT_DEF;
  localparam int HB  = CPB / 2;
  localparam logic [1:0] K_VALID = 2'b10;
  localparam logic [1:0] K_FERR  = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] d;
    int         at;
    int         low_before;
  } ev_t;

  ev_t evq[$];
  int  busy_low = 0;
  int  last_start = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Monitor: log every cycle with a pulse high, plus busy-low cycles since the last one.
  always @(negedge clk) begin
    if (!busy) busy_low++;
    if (data_valid || frame_err) begin
      evq.push_back('{kind: {data_valid, frame_err}, d: data, at: cyc, low_before: busy_low});
      busy_low = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int p, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    last_start = cyc;
    drive_level(1'b0, p - 1);
    for (int i = 0; i < 8; i++) drive_level(b[i], p);
    drive_level(stop, p);
  endtask

  task automatic expect_event(input string name, input logic [1:0] kind,
                              input logic [7:0] d, output ev_t e);
    int w = 0;
    while (evq.size() == 0 && w < 4 * CPB) begin
      @(negedge clk);
      w++;
    end
    e = '{kind: 2'b00, d: 8'h00, at: 0, low_before: 0};
    if (evq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no output pulse within %0d cycles", name, 4 * CPB);
    end else begin
      e = evq.pop_front();
      check({name, " kind"}, 32'(e.kind), 32'(kind));
      check({name, " data"}, 32'(e.d), 32'(d));
    end
  endtask

  task automatic expect_quiet(input string name);
    check({name, " no pulse"}, evq.size(), 0);
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] b;
    int         p;
    logic       stop;
    int         gap;
    logic [1:0] kind;
    logic [7:0] d;
  } vec_t;

  vec_t vt[8];
  ev_t  e;

  initial begin
    vt[0] = '{b: 8'h5A, p: 88, stop: 1'b1, gap: 10, kind: K_VALID, d: 8'h5A};
    vt[1] = '{b: 8'h01, p: 88, stop: 1'b1, gap: 0,  kind: K_VALID, d: 8'h01};
    vt[2] = '{b: 8'h80, p: 88, stop: 1'b1, gap: 3,  kind: K_VALID, d: 8'h80};
    vt[3] = '{b: 8'hE7, p: 88, stop: 1'b0, gap: 20, kind: K_FERR,  d: 8'hE7};
    vt[4] = '{b: 8'h33, p: 87, stop: 1'b1, gap: 1,  kind: K_VALID, d: 8'h33};
    vt[5] = '{b: 8'hFE, p: 89, stop: 1'b1, gap: 0,  kind: K_VALID, d: 8'hFE};
    vt[6] = '{b: 8'h00, p: 88, stop: 1'b0, gap: 5,  kind: K_FERR,  d: 8'h00};
    vt[7] = '{b: 8'h96, p: 88, stop: 1'b1, gap: 15, kind: K_VALID, d: 8'h96};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset data", 32'(data), 32'h00);
    check("reset data_valid", 32'(data_valid), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    drive_level(1'b1, 10);

    // Good frame 0xA5 with exact pulse timing.
    send_frame(8'hA5, CPB, 1'b1);
    drive_level(1'b1, 10);
    expect_event("a5", K_VALID, 8'hA5, e);
    check("a5 pulse cycle", e.at, last_start + 3 + HB + 9 * CPB);
    expect_quiet("a5 single pulse");
    check("a5 idle busy", 32'(busy), 0);

    // Glitch: 20 cycles low, then idle.
    drive_level(1'b0, 20);
    drive_level(1'b1, 100);
    expect_quiet("glitch");
    check("glitch data kept", 32'(data), 32'hA5);
    check("glitch busy", 32'(busy), 0);

    // Frame error then break held low for 300 cycles from the stop bit.
    send_frame(8'h3C, CPB, 1'b0);
    drive_level(1'b0, 300 - CPB);
    expect_event("brk 3c", K_FERR, 8'h3C, e);
    check("brk data", 32'(data), 32'h3C);
    check("brk busy held", 32'(busy), 1);
    expect_quiet("brk no retrigger");
    drive_level(1'b1, 5);
    check("brk released", 32'(busy), 0);
    send_frame(8'h55, CPB, 1'b1);
    drive_level(1'b1, 10);
    expect_event("after brk 55", K_VALID, 8'h55, e);

    // Back-to-back frames with no idle gap between stop and start.
    send_frame(8'h00, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    drive_level(1'b1, 10);
    expect_event("b2b 00", K_VALID, 8'h00, e);
    expect_event("b2b ff", K_VALID, 8'hFF, e);
    check("b2b short busy gap", 32'(e.low_before >= 1 && e.low_before < CPB), 1);

    // Reset during bit 4 of 0x81, released on an idle line.
    @(negedge clk);
    rx = 1'b0;
    drive_level(1'b0, CPB - 1);
    drive_level(1'b1, CPB);
    drive_level(1'b0, 3 * CPB);
    drive_level(1'b0, HB);
    expect_quiet("pre reset");
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("mid reset data", 32'(data), 32'h00);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset pulses", 32'({data_valid, frame_err}), 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    drive_level(1'b1, 2 * CPB);
    expect_quiet("post reset");
    check("post reset data", 32'(data), 32'h00);
    send_frame(8'h81, CPB, 1'b1);
    drive_level(1'b1, 10);
    expect_event("post reset 81", K_VALID, 8'h81, e);

    // Transmitter period offset of about 2 percent either way.
    send_frame(8'hC3, 86, 1'b1);
    drive_level(1'b1, 10);
    expect_event("c3 at 86", K_VALID, 8'hC3, e);
    send_frame(8'hC3, 90, 1'b1);
    drive_level(1'b1, 10);
    expect_event("c3 at 90", K_VALID, 8'hC3, e);

    // Table of frames.
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].b, vt[i].p, vt[i].stop);
      drive_level(1'b1, vt[i].gap);
      expect_event($sformatf("vec%0d", i), vt[i].kind, vt[i].d, e);
      check($sformatf("vec%0d data port", i), 32'(data), 32'(vt[i].d));
    end

    // Random frames against the frame-level model: the byte is delivered
    // unchanged, flagged good when the stop bit is high and bad otherwise.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic       stop;
      int         p;
      int         gap;
      b    = 8'($urandom);
      p    = $urandom_range(86, 90);
      stop = ($urandom_range(0, 5) != 0);
      gap  = stop ? $urandom_range(0, 30) : $urandom_range(2, 30);
      send_frame(b, p, stop);
      drive_level(1'b1, gap);
      expect_event($sformatf("rand%0d", i), stop ? K_VALID : K_FERR, b, e);
    end
    drive_level(1'b1, 2 * CPB);
    expect_quiet("final");
    check("final busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver, 8N1 (1 start, 8 data LSB-first, 1 stop), no parity.
- Counterpart to the transmit path driven by the 88-clock bit period from the baud generator.
- Derives its own mid-bit sample timing from `clk`, so no external baud tick is needed.
- Sits between the external RX pin and the byte-level consumer logic.

Parameters:
- CLKS_PER_BIT, 88, clk cycles per bit period; legal range ≥ 4, must match the transmitter's period.
- HALF_BIT, CLKS_PER_BIT/2 (44), offset from start-edge detection to the start-bit centre sample.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this release.

Ports:
- clk, input, 1, system clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rx, input, 1, serial line, asynchronous to clk; idle high.
- data, output, 8, last received byte; holds until the next frame's stop sample.
- data_valid, output, 1, one-cycle pulse: good frame received, `data` updated.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low, `data` updated anyway.
- busy, output, 1, high from start-edge detection until return to IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, `data` = 0x00, `data_valid` = `frame_err` = `busy` = 0.
  - Bit counter and clk counter = 0; both synchronizer flops = 1.
- Input sync: `rx` passes through 2 flops giving `rx_s`; `rx_s` lags `rx` by 2 clk. All decisions use `rx_s` only.
- IDLE:
  - `rx_s` == 0 in cycle T0 → START, counter cleared, `busy` = 1 from T0+1.
- START:
  - Counter runs to HALF_BIT.
  - At T0+HALF_BIT, sample `rx_s`: 0 → DATA with counter cleared; 1 → glitch, back to IDLE, no output pulse.
- DATA:
  - Bit i (i = 0..7) sampled at T0 + HALF_BIT + CLKS_PER_BIT·(i+1).
  - Shifted into a shift register LSB-first.
  - After bit 7 → STOP.
- STOP:
  - Sampled at T0 + HALF_BIT + 9·CLKS_PER_BIT.
  - `rx_s` == 1: `data` ← shift register, `data_valid` = 1 next cycle for exactly one clk → IDLE.
  - `rx_s` == 0: `data` ← shift register, `frame_err` = 1 next cycle for one clk → BRK.
- BRK:
  - Wait until `rx_s` == 1 for 1 clk, then → IDLE.
  - Prevents a held-low line (break) from retriggering reception.
  - `busy` stays 1 in BRK.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit centre.
  - A start edge arriving ≥ 1 clk later is accepted, so the next frame may begin half a bit after the stop sample.
- Pulse exclusivity: `data_valid` and `frame_err` are never high in the same cycle.
- Mid-frame reset: all state abandoned immediately; partial byte discarded; no pulse after release.
- Width rules:
  - Counter width = $clog2(CLKS_PER_BIT); it compares against CLKS_PER_BIT-1 and wraps to 0, with no overflow.
  - Bit counter is 3 bits.
- States: IDLE, START, DATA, STOP, BRK; binary encoded.

Decomposition:
- Shared package `uart_pkg`:
  - Constants CLKS_PER_BIT_DEF = 88 and DATA_BITS = 8.
  - Receiver state enum (IDLE/START/DATA/STOP/BRK).
  - The future transmitter imports the same package so both ends share the bit period.
- Sub-module `sync2`:
  - Generic 2-flop synchronizer with reset value parameter (here 1).
  - Reused for any other async input.
- Everything else (counter, FSM, shift register) stays in `uart_rx`.

Test Plan:
- Frame 0xA5 at 88 clk/bit with good stop → `data` = 0xA5 and `data_valid` high one clk at T0+44+9·88+1; `frame_err` stays 0.
- `rx` low for 20 clk then high (glitch) → return to IDLE at T0+44; no `data_valid`/`frame_err`; `data` unchanged.
- Frame 0x3C with stop bit low, `rx` held low for 300 clk → `frame_err` one-clk pulse and `data` = 0x3C. No new frame starts until `rx` rises; the next good frame 0x55 then yields `data_valid` with `data` = 0x55.
- Back-to-back 0x00 then 0xFF, second start bit immediately after first stop bit → two `data_valid` pulses; `data` = 0x00 then 0xFF; `busy` drops only briefly between frames.
- `rst_n` asserted during bit 4 of 0x81, released 10 clk later on an idle line → outputs zero immediately. The rest of that frame is ignored because `rx_s` is high before the next falling edge. The following frame 0x81 is received correctly.
- Transmitter period offset of ±2% (86 and 90 clk/bit) sending 0xC3 → `data` = 0xC3 with `data_valid` in both cases.
